// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_NREAD = 2;

  // Never narrower than one bit, even for the smallest legal array.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, zero/out-of-range forcing and,
// when REGFILE_BYPASS_EN is defined, forwarding of the write accepted this cycle.
module regfile_read_port #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31,
  parameter int ADDR_W   = 5
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]           readReg,
  input  logic                        writeEn,
  input  logic [ADDR_W-1:0]           writeReg,
  input  logic [WIDTH-1:0]            writeData,
  output logic [WIDTH-1:0]            readData
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic readable;

  assign readable = (readReg != ZERO_IDX) && (32'(readReg) < DEPTH);

`ifdef REGFILE_BYPASS_EN
  // writeEn is already qualified (no zero reg, no clear in progress), so forwarding is safe.
  always_comb begin
    readData = '0;
    if (readable) begin
      if (writeEn && (writeReg == readReg)) readData = writeData;
      else                                  readData = regs[readReg];
    end
  end
`else
  logic unused_write_port;

  assign unused_write_port = ^{writeEn, writeReg, writeData};

  always_comb begin
    readData = '0;
    if (readable) readData = regs[readReg];
  end
`endif

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with a hardwired-zero entry and a
// one-entry-per-cycle clear sequencer. Bypass option: REGFILE_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = DEFAULT_WIDTH,
  parameter int  DEPTH    = DEFAULT_DEPTH,
  parameter int  NREAD    = DEFAULT_NREAD,
  parameter int  ZERO_REG = DEPTH - 1,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         regWrite,
  input  logic [ADDR_W-1:0]            writeReg,
  input  logic [WIDTH-1:0]             writeData,
  input  logic [NREAD-1:0][ADDR_W-1:0] readReg,
  output logic [NREAD-1:0][WIDTH-1:0]  readData,
  input  logic                         clearReq,
  output logic                         clearBusy,
  output logic                         clearDone
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  clear_state_t                state;
  logic [ADDR_W-1:0]           ptr;
  logic                        wr_accept;

  assign wr_accept = regWrite && (state != CLEAR) &&
                     (writeReg != ZERO_IDX) && (32'(writeReg) < DEPTH);

  // The clear sequencer owns the array while busy; ptr never leaves [0, DEPTH-1].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else if (state == CLEAR) begin
      regs[ptr] <= '0;
    end else if (wr_accept) begin
      regs[writeReg] <= writeData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clearReq) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          if (ptr == LAST_IDX) begin
            state <= DONE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign clearBusy = (state == CLEAR);
  assign clearDone = (state == DONE);

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    regfile_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .ADDR_W  (ADDR_W)
    ) u_read_port (
      .regs     (regs),
      .readReg  (readReg[p]),
      .writeEn  (wr_accept),
      .writeReg (writeReg),
      .writeData(writeData),
      .readData (readData[p])
    );
  end

endmodule
